// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The LSU takes the slave view; the core/memory environment takes the master view.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  stall;
  logic                  misalign;
  logic                  dm_wr_en;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wr_data;
  logic [DATA_WIDTH-1:0] dm_rd_data;

  modport master (
    output mem_req, mem_we, funct3, addr, wdata, dm_rd_data,
    input  rdata, stall, misalign, dm_wr_en, dm_addr, dm_wr_data
  );

  modport slave (
    input  mem_req, mem_we, funct3, addr, wdata, dm_rd_data,
    output rdata, stall, misalign, dm_wr_en, dm_addr, dm_wr_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a word-only data memory: load extraction/extension,
// read-modify-write for SB/SH, misalignment suppression. LSU_FAULT_CNT_EN adds fault_cnt.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  load_store_unit_if.slave     bus
`ifdef LSU_FAULT_CNT_EN
  ,
  output logic [15:0]          fault_cnt
`endif
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] merge_q, merge_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  valid_op;
  logic                  misaligned;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] merged;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [31:0] s;
    s = $signed(b);
    return sgn ? s : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [31:0] s;
    s = $signed(h);
    return sgn ? s : {16'b0, h};
  endfunction

  always_comb begin
    byte_lane = bus.dm_rd_data[{bus.addr[1:0], 3'b000} +: 8];
    half_lane = bus.dm_rd_data[{bus.addr[1], 4'b0000} +: 16];

    // Stores only exist for byte/half/word; the unsigned encodings are load-only.
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: valid_op = 1'b1;
      3'b100, 3'b101:         valid_op = !bus.mem_we;
      default:                valid_op = 1'b0;
    endcase

    case (bus.funct3[1:0])
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = |bus.addr[1:0];
      default: misaligned = 1'b0;
    endcase

    case (bus.funct3)
      3'b000:  load_word = ext_byte(byte_lane, 1'b1);
      3'b100:  load_word = ext_byte(byte_lane, 1'b0);
      3'b001:  load_word = ext_half(half_lane, 1'b1);
      3'b101:  load_word = ext_half(half_lane, 1'b0);
      default: load_word = bus.dm_rd_data;
    endcase

    merged = bus.dm_rd_data;
    if (bus.funct3[0]) merged[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
    else               merged[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
  end

  always_comb begin
    state_d        = state_q;
    merge_d        = merge_q;
    addr_d         = addr_q;
    bus.rdata      = '0;
    bus.stall      = 1'b0;
    bus.misalign   = 1'b0;
    bus.dm_wr_en   = 1'b0;
    bus.dm_addr    = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
    bus.dm_wr_data = bus.wdata;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (bus.mem_req && valid_op) begin
            if (misaligned) begin
              bus.misalign = 1'b1;
            end else if (!bus.mem_we) begin
              bus.rdata = load_word;
            end else if (bus.funct3[1]) begin
              bus.dm_wr_en = 1'b1;
            end else begin
              // Partial store: capture the merged word now, write it next cycle.
              bus.stall = 1'b1;
              merge_d   = merged;
              addr_d    = bus.addr;
              state_d   = WRITE;
            end
          end
        end
        WRITE: begin
          bus.dm_wr_en   = 1'b1;
          bus.dm_wr_data = merge_q;
          bus.dm_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
    end
  end

`ifdef LSU_FAULT_CNT_EN
  logic [15:0] fault_cnt_q, fault_cnt_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb fault_cnt_d = bus.misalign ? sat_inc16(fault_cnt_q) : fault_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_cnt_q <= '0;
    else       fault_cnt_q <= fault_cnt_d;
  end

  assign fault_cnt = fault_cnt_q;
`else
  // Without the counter, misalignment is reported only on the misalign output.
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference model checked every cycle,
// plus directed literal expectations from the test plan.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

`ifdef LSU_FAULT_CNT_EN
  logic [15:0] fault_cnt;
`endif

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef LSU_FAULT_CNT_EN
    ,
    .fault_cnt (fault_cnt)
`endif
  );

  // Data memory: async read, sync write, plus a bench-only preload path.
  logic [31:0] mem [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;

  assign bus.dm_rd_data = mem[bus.dm_addr[7:2]];

  always @(posedge clk) begin
    if (pl_en)             mem[pl_a] <= pl_d;
    else if (bus.dm_wr_en) mem[bus.dm_addr[7:2]] <= bus.dm_wr_data;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: flat byte memory plus a pending partial store.
  logic [7:0]  ref_b [256];
  logic        pend = 1'b0;
  logic [7:0]  pend_a;
  int          pend_n;
  logic [31:0] pend_d;
  int          exp_fc = 0;

  function automatic logic [31:0] rd_bytes(input logic [7:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[a + 8'(i)];
    return v;
  endfunction

  task automatic wr_bytes(input logic [7:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) ref_b[a + 8'(i)] = d[8*i +: 8];
  endtask

  always @(negedge clk) begin : compare
    logic [31:0] e_rd, e_wd, e_da, v;
    logic        e_st, e_mis, e_we, valid;
    logic [7:0]  a, base;
    int          n;
    e_rd = '0; e_wd = '0; e_da = '0;
    e_st = 1'b0; e_mis = 1'b0; e_we = 1'b0;
    if (reset) begin
      pend   = 1'b0;
      exp_fc = 0;
    end else if (pend) begin
      base = {pend_a[7:2], 2'b00};
      v = rd_bytes(base, 4);
      for (int i = 0; i < pend_n; i++) v[8*(int'(pend_a[1:0]) + i) +: 8] = pend_d[8*i +: 8];
      e_we = 1'b1;
      e_wd = v;
      e_da = {24'b0, base};
      wr_bytes(base, 4, v);
      pend = 1'b0;
    end else if (bus.mem_req) begin
      a = bus.addr[7:0];
      n = 1 << bus.funct3[1:0];
      valid = (bus.funct3 inside {3'd0, 3'd1, 3'd2}) ||
              (!bus.mem_we && (bus.funct3 inside {3'd4, 3'd5}));
      if (valid) begin
        if ((int'(a) % n) != 0) begin
          e_mis = 1'b1;
        end else if (!bus.mem_we) begin
          v = rd_bytes(a, n);
          if (!bus.funct3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
          e_rd = v;
        end else if (n == 4) begin
          e_we = 1'b1;
          e_wd = bus.wdata;
          e_da = {24'b0, a[7:2], 2'b00};
          wr_bytes(a, 4, bus.wdata);
        end else begin
          e_st   = 1'b1;
          pend   = 1'b1;
          pend_a = a;
          pend_n = n;
          pend_d = bus.wdata;
        end
      end
    end
    chk("m_stall", 32'(bus.stall), 32'(e_st));
    chk("m_misalign", 32'(bus.misalign), 32'(e_mis));
    chk("m_wr_en", 32'(bus.dm_wr_en), 32'(e_we));
    chk("m_rdata", bus.rdata, e_rd);
    if (e_we) begin
      chk("m_wr_data", bus.dm_wr_data, e_wd);
      chk("m_dm_addr", bus.dm_addr, e_da);
    end
`ifdef LSU_FAULT_CNT_EN
    chk("m_fault_cnt", 32'(fault_cnt), 32'(exp_fc));
    if (e_mis && exp_fc < 65535) exp_fc++;
`endif
  end

  task automatic drive(input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.mem_req = req;
    bus.mem_we  = we;
    bus.funct3  = f3;
    bus.addr    = a;
    bus.wdata   = wd;
  endtask

  task automatic ld(input string nm, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] exp);
    drive(1'b1, 1'b0, f3, a, 32'h0);
    @(negedge clk);
    chk(nm, bus.rdata, exp);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    @(posedge clk);
    #1;
    pl_en = 1'b1;
    pl_a  = a[7:2];
    pl_d  = w;
    wr_bytes(a, 4, w);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
    // A word store presented during reset must not reach memory.
    bus.mem_req = 1'b1;
    bus.mem_we  = 1'b1;
    bus.funct3  = 3'b010;
    bus.addr    = 32'h08;
    bus.wdata   = 32'hFFFF_FFFF;

    @(negedge clk);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_wr_en", 32'(bus.dm_wr_en), 32'h0);
    chk("rst_misalign", 32'(bus.misalign), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);

    for (int i = 0; i < 64; i++) preload(8'(4 * i), 32'h0);
    preload(8'h10, 32'h1122_3344);
    preload(8'h20, 32'h0000_80FF);
    preload(8'h04, 32'h5566_7788);
    @(posedge clk);
    #1;
    pl_en       = 1'b0;
    bus.mem_req = 1'b0;
    reset       = 1'b0;

    ld("lb_13", 3'b000, 32'h13, 32'h0000_0011);
    ld("lbu_10", 3'b100, 32'h10, 32'h0000_0044);
    ld("lh_12", 3'b001, 32'h12, 32'h0000_1122);
    ld("lb_20", 3'b000, 32'h20, 32'hFFFF_FFFF);
    ld("lh_20", 3'b001, 32'h20, 32'hFFFF_80FF);
    ld("lhu_20", 3'b101, 32'h20, 32'h0000_80FF);
    ld("bad_f3", 3'b011, 32'h10, 32'h0000_0000);

    // SB with a competing word store during WRITE, which must be ignored.
    drive(1'b1, 1'b1, 3'b000, 32'h11, 32'h0000_00AB);
    @(negedge clk);
    chk("sb_stall", 32'(bus.stall), 32'h1);
    chk("sb_no_wr", 32'(bus.dm_wr_en), 32'h0);
    drive(1'b1, 1'b1, 3'b010, 32'h30, 32'h9999_9999);
    @(negedge clk);
    chk("sb_wr_en", 32'(bus.dm_wr_en), 32'h1);
    chk("sb_wr_data", bus.dm_wr_data, 32'h1122_AB44);
    chk("sb_stall2", 32'(bus.stall), 32'h0);
    ld("lw_after_sb", 3'b010, 32'h10, 32'h1122_AB44);
    chk("ignored_sw", mem[12], 32'h0);

    drive(1'b1, 1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_wr_en", 32'(bus.dm_wr_en), 32'h1);
    chk("sw_stall", 32'(bus.stall), 32'h0);
    ld("lw_08", 3'b010, 32'h08, 32'hDEAD_BEEF);

    // Back-to-back partial stores into the same word.
    drive(1'b1, 1'b1, 3'b001, 32'h22, 32'h0000_1234);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 3'b000, 32'h20, 32'h0000_005A);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    ld("lw_20_merged", 3'b010, 32'h20, 32'h1234_805A);

    drive(1'b1, 1'b0, 3'b010, 32'h06, 32'h0);
    @(negedge clk);
    chk("lw06_misalign", 32'(bus.misalign), 32'h1);
    chk("lw06_rdata", bus.rdata, 32'h0);
    drive(1'b1, 1'b1, 3'b001, 32'h05, 32'h0000_FFFF);
    @(negedge clk);
    chk("sh05_misalign", 32'(bus.misalign), 32'h1);
    chk("sh05_stall", 32'(bus.stall), 32'h0);
    chk("sh05_wr_en", 32'(bus.dm_wr_en), 32'h0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    chk("mis_mem_intact", mem[1], 32'h5566_7788);
`ifdef LSU_FAULT_CNT_EN
    chk("fault_cnt_2", 32'(fault_cnt), 32'h2);
`endif

    // Reset during WRITE aborts the pending SH.
    drive(1'b1, 1'b1, 3'b001, 32'h12, 32'h0000_BEEF);
    @(negedge clk);
    chk("sh12_stall", 32'(bus.stall), 32'h1);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    bus.mem_req = 1'b0;
    @(negedge clk);
    chk("abort_wr_en", 32'(bus.dm_wr_en), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_mem_intact", mem[4], 32'h1122_AB44);
    ld("lw_after_abort", 3'b010, 32'h10, 32'h1122_AB44);

    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the core datapath and the word-only data memory (32-bit async read, sync full-word write). Decodes RV32I load/store size from `funct3`, extracts and sign- or zero-extends load data, and turns byte/halfword stores into a two-cycle read-modify-write with a stall to the core. Detects misaligned accesses and suppresses them.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width; only 32 supported.
- `ADDR_WIDTH`, 32, byte address width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; forces `IDLE` immediately.
- `mem_req`  in  1  core requests a load or store this cycle.
- `mem_we`  in  1  1 = store, 0 = load; qualified by `mem_req`.
- `funct3`  in  3  RV32I size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `addr`  in  ADDR_WIDTH  byte address from ALU.
- `wdata`  in  DATA_WIDTH  store data (rs2).
- `rdata`  out  DATA_WIDTH  extended load result to writeback.
- `stall`  out  1  hold PC and register-file write this cycle.
- `misalign`  out  1  current request is misaligned and suppressed.
- `dm_wr_en`  out  1  data-memory write enable.
- `dm_addr`  out  ADDR_WIDTH  data-memory byte address.
- `dm_wr_data`  out  DATA_WIDTH  full word to write.
- `dm_rd_data`  in  DATA_WIDTH  word read combinationally from data memory.

## Operation
- States: `IDLE`, `WRITE`. Registers: `state`, `merge_q` (32), `addr_q` (ADDR_WIDTH).
- `dm_addr` = `{addr[ADDR_WIDTH-1:2], 2'b00}` in `IDLE`; `addr_q` word-aligned in `WRITE`.
- Alignment: LH/LHU/SH misaligned if `addr[0]`=1; LW/SW if `addr[1:0]`≠0; byte ops never misaligned.
- Misaligned or funct3 ∈ {011, 110, 111}: no write, no stall, `rdata`=0. `misalign`=1 only for misalignment.
- Load (IDLE): byte/half lane selected by `addr[1:0]` / `addr[1]`; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word. Combinational, 0 stall.
- SW aligned (IDLE): `dm_wr_en`=1, `dm_wr_data`=`wdata`, `stall`=0; memory writes on this edge.
- SB/SH aligned (IDLE): `stall`=1, `dm_wr_en`=0. On the edge, `merge_q` ← `dm_rd_data` with the target lane replaced by `wdata[7:0]` / `wdata[15:0]`; `addr_q` ← `addr`; → `WRITE`.
- `WRITE`: `dm_wr_en`=1, `dm_wr_data`=`merge_q`, `stall`=0; → `IDLE`. Core inputs are ignored in this state, including a `mem_req` drop.
- `mem_req`=0 in `IDLE`: all outputs inactive, `rdata`=0.

## Timing
- Reset values: `state`=`IDLE`, `merge_q`=0, `addr_q`=0. While `reset`=1: `stall`, `misalign`, `dm_wr_en` are 0 and `rdata`=0.
- Reset asserted in `WRITE` aborts the pending write: no `dm_wr_en` pulse, and memory is unchanged.
- Latency: loads 0 cycles (same-cycle `rdata`); SW 1 edge; SB/SH 2 edges, with `stall` high for exactly the first cycle.
- Back-to-back: a request presented in the cycle after `WRITE` is accepted normally. A load to the just-written word sees the merged data.
- `stall` and `misalign` are never both 1.

## Configuration
- `LSU_FAULT_CNT_EN` defined: adds output `fault_cnt` [15:0]. It increments on each rising edge where `misalign`=1, saturates at 16'hFFFF, and is cleared by `reset`.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

## Test plan
- Reset, then preload word 0x11223344 at byte address 0x10; LB@0x13 → `rdata`=0x00000011; LBU@0x10 → 0x00000044; LH@0x12 → 0x00001122.
- Preload 0x0000_80FF at 0x20; LB@0x20 → 0xFFFFFFFF; LH@0x20 → 0xFFFF80FF; LHU@0x20 → 0x000080FF.
- SB 0xAB@0x11 over 0x11223344 → `stall`=1 for 1 cycle, then `dm_wr_en`=1 with 0x1122AB44; LW@0x10 → 0x1122AB44.
- SW 0xDEADBEEF@0x08 → `dm_wr_en`=1 in the same cycle, `stall`=0; LW@0x08 → 0xDEADBEEF.
- LW@0x06 and SH@0x05 → `misalign`=1, no `dm_wr_en`, memory unchanged. With `LSU_FAULT_CNT_EN`, `fault_cnt`=2.
- SH 0xBEEF@0x12, then assert `reset` during `WRITE` → no write, `state`=`IDLE`, original word intact.
